// File: rtl/data_bus_bridge.sv
// data_bus_bridge: turns the core's single-cycle data access into a
// request/grant/response transaction on a variable-latency memory bus.
// The core is stalled while the transaction is outstanding. A response
// timeout ends the access with an error instead of hanging the pipeline.
module data_bus_bridge #(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  // Counter is wide enough to hold TIMEOUT_CYCLES; it saturates at all-ones.
  localparam int CNT_W      = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int TMO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_LAST_I);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             addr_lsb_unused;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Alignment is owned by the memory stage; the low address bits are only masked.
  assign addr_lsb_unused = ^cpu_addr[1:0];

  // The current REQ/RESP cycle is the last one allowed (counter holds cycles already spent).
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

  // Stall rises in the same cycle the core presents the access, and drops only in DONE.
  assign cpu_stall = ((state == IDLE) && cpu_en) || (state == REQ) || (state == RESP);

  // Transaction FSM with registered bus outputs, read data and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= 4'h0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      cpu_rdata <= 32'h0;
      bus_err   <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_en) begin
            bus_addr  <= {cpu_addr[31:2], 2'b00};
            bus_we    <= |cpu_wen;
            bus_be    <= (|cpu_wen) ? cpu_wen : 4'hF;
            bus_wdata <= cpu_wdata;
            bus_err   <= 1'b0;
            tmo_cnt   <= '0;
            bus_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          tmo_cnt <= sat_inc(tmo_cnt);
          if (tmo_hit) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            if (!bus_we) cpu_rdata <= ERR_RDATA;
            state   <= DONE;
          end else if (bus_gnt) begin
            bus_req <= 1'b0;
            state   <= RESP;
          end
        end
        RESP: begin
          tmo_cnt <= sat_inc(tmo_cnt);
          // A response landing on the timeout cycle still completes normally.
          if (bus_rvalid) begin
            if (!bus_we) cpu_rdata <= bus_rdata;
            state <= DONE;
          end else if (tmo_hit) begin
            bus_err <= 1'b1;
            if (!bus_we) cpu_rdata <= ERR_RDATA;
            state   <= DONE;
          end
        end
        DONE: begin
          // cpu_en is still the old, held request here; never reissue it.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Testbench for data_bus_bridge: table of accesses with a bus responder,
// a grant-side scoreboard, and hand-written reset sequences.
module tb_data_bus_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_en = 1'b0;
  logic [3:0]  cpu_wen = 4'h0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_err;

  always #5 clk = ~clk;

  data_bus_bridge #(
    .TIMEOUT_CYCLES(8),
    .ERR_RDATA     (32'hDEAD_BEEF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_en    (cpu_en),
    .cpu_wen   (cpu_wen),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_be    (bus_be),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_gnt   (bus_gnt),
    .bus_rvalid(bus_rvalid),
    .bus_rdata (bus_rdata),
    .bus_err   (bus_err)
  );

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gnt_dly;   // REQ cycles before gnt; -1 = never
    int          rv_dly;    // RESP cycles before rvalid
    logic [31:0] rdata;
    bit          hold;      // keep cpu_en high through DONE
    logic [31:0] exp_rdata;
    int          exp_stall;
    int          exp_req;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  bus_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] wen, input logic [31:0] addr,
                              input logic [31:0] wdata, input int gd, input int rd,
                              input logic [31:0] rdata, input bit hold,
                              input logic [31:0] er, input int es, input int eq,
                              input logic ee);
    vec_t v;
    v.wen = wen; v.addr = addr; v.wdata = wdata; v.gnt_dly = gd; v.rv_dly = rd;
    v.rdata = rdata; v.hold = hold; v.exp_rdata = er; v.exp_stall = es;
    v.exp_req = eq; v.exp_err = ee;
    return v;
  endfunction

  // Scoreboard: every accepted request must match the oldest issued access.
  always @(negedge clk) begin
    bus_t e;
    if (rst && bus_req && bus_gnt) begin
      if (exp_q.size() == 0) begin
        check("grant with no access pending", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("sb bus_addr", bus_addr, e.addr);
        check("sb bus_we", {31'b0, bus_we}, {31'b0, e.we});
        check("sb bus_be", {28'b0, bus_be}, {28'b0, e.be});
        check("sb bus_wdata", bus_wdata, e.wdata);
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int   stall_cnt, req_cyc, resp_wait, cyc;
    bit   granted, done, stable;
    bus_t e;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    cpu_en = 1'b1; cpu_wen = v.wen; cpu_addr = v.addr; cpu_wdata = v.wdata;
    e.addr  = {v.addr[31:2], 2'b00};
    e.we    = (v.wen != 4'h0);
    e.be    = (v.wen != 4'h0) ? v.wen : 4'hF;
    e.wdata = v.wdata;
    if (v.gnt_dly >= 0) exp_q.push_back(e);
    #1;
    stall_cnt = cpu_stall ? 1 : 0;
    req_cyc = 0; resp_wait = 0; granted = 0; done = 0; stable = 1; cyc = 0;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (!v.hold) cpu_en = 1'b0;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
      if (bus_req) begin
        req_cyc++;
        if (bus_addr !== e.addr || bus_be !== e.be || bus_we !== e.we || bus_wdata !== e.wdata)
          stable = 0;
        if (v.gnt_dly >= 0 && req_cyc == v.gnt_dly + 1) begin
          bus_gnt = 1'b1;
          granted = 1;
        end
      end else if (granted) begin
        resp_wait++;
        if (resp_wait == v.rv_dly + 1) begin
          bus_rvalid = 1'b1;
          bus_rdata  = v.rdata;
        end
      end
      #1;
      if (cpu_stall) stall_cnt++;
      else done = 1;
    end
    if (!done) check({tag, " completion within bound"}, 32'd0, 32'd1);
    check({tag, " stall cycles"}, 32'(stall_cnt), 32'(v.exp_stall));
    check({tag, " req cycles"}, 32'(req_cyc), 32'(v.exp_req));
    check({tag, " req fields stable"}, {31'b0, stable}, 32'd1);
    check({tag, " cpu_rdata in DONE"}, cpu_rdata, v.exp_rdata);
    check({tag, " bus_err in DONE"}, {31'b0, bus_err}, {31'b0, v.exp_err});
    check({tag, " bus_req low in DONE"}, {31'b0, bus_req}, 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " bus_req"}, {31'b0, bus_req}, 32'd0);
    check({tag, " bus_we"}, {31'b0, bus_we}, 32'd0);
    check({tag, " bus_be"}, {28'b0, bus_be}, 32'd0);
    check({tag, " bus_addr"}, bus_addr, 32'd0);
    check({tag, " bus_wdata"}, bus_wdata, 32'd0);
    check({tag, " cpu_rdata"}, cpu_rdata, 32'd0);
    check({tag, " bus_err"}, {31'b0, bus_err}, 32'd0);
    check({tag, " cpu_stall"}, {31'b0, cpu_stall}, 32'd0);
  endtask

  initial begin
    bus_t e;
    //            wen    addr          wdata         gd  rd  rdata         hold exp_rdata     stall req err
    vecs[0] = mk(4'h0, 32'h0000_1006, 32'h0,         0,  0, 32'h1234_5678, 0, 32'h1234_5678, 3, 1, 1'b0);
    vecs[1] = mk(4'h4, 32'h0000_2000, 32'h00AB_0000, 3,  2, 32'hFFFF_0000, 0, 32'h1234_5678, 8, 4, 1'b0);
    vecs[2] = mk(4'h0, 32'h0000_3003, 32'h0,         1,  1, 32'hA5A5_5A5A, 1, 32'hA5A5_5A5A, 5, 2, 1'b0);
    vecs[3] = mk(4'h0, 32'h0000_4008, 32'h0,         0,  0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 3, 1, 1'b0);
    vecs[4] = mk(4'h0, 32'h0000_5000, 32'h0,        -1,  0, 32'h0,         0, 32'hDEAD_BEEF, 9, 8, 1'b1);
    vecs[5] = mk(4'hF, 32'h0000_5004, 32'h5555_AAAA,-1,  0, 32'h0,         0, 32'hDEAD_BEEF, 9, 8, 1'b1);
    vecs[6] = mk(4'h0, 32'h0000_6000, 32'h0,         0,  0, 32'h1111_2222, 0, 32'h1111_2222, 3, 1, 1'b0);
    vecs[7] = mk(4'h0, 32'h0000_7000, 32'h0,         0,  6, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 9, 1, 1'b0);
    vecs[8] = mk(4'hF, 32'h0000_8001, 32'h0102_0304, 0,  0, 32'h7777_0000, 0, 32'hCAFE_F00D, 3, 1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Reset while waiting for the response: outputs clear without a clock edge.
    @(posedge clk); #1;
    cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h0000_9000; cpu_wdata = 32'h0;
    e.addr = 32'h0000_9000; e.we = 1'b0; e.be = 4'hF; e.wdata = 32'h0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    cpu_en = 1'b0; bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    #1;
    check("mid-RESP stall", {31'b0, cpu_stall}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_reset_values("async reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    bus_rvalid = 1'b1; bus_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    @(posedge clk); #1;
    check("late rvalid cpu_rdata", cpu_rdata, 32'h0);
    check("late rvalid stall", {31'b0, cpu_stall}, 32'd0);
    check("late rvalid bus_req", {31'b0, bus_req}, 32'd0);

    // The bridge must be usable again after the reset.
    run_vec(mk(4'h0, 32'h0000_A004, 32'h0, 0, 0, 32'h0F0F_0F0F, 0, 32'h0F0F_0F0F, 3, 1, 1'b0), 9);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_bus_bridge.md
Name: data_bus_bridge

Overview:
- Sits directly downstream of the CPU core's data port (data_en/data_wen/data_addr/data_wdata/data_rdata).
- Converts that single-cycle access into a request/grant/response transaction on a variable-latency memory bus.
- Raises a stall toward the core for as long as the transaction is outstanding.
- Adds a response timeout so a dead slave reports an error instead of hanging the pipeline.

Parameters:
- TIMEOUT_CYCLES, 256: maximum cycles spent in REQ+RESP before the access is aborted; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF: value returned on cpu_rdata when an access times out.

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_en  in  1  access request from the core (read or write)
- cpu_wen  in  4  byte write enables; 0 = read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  read data, valid in DONE and held until the next access completes
- cpu_stall  out  1  core must hold its memory stage while high
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_be  out  4  byte enables (cpu_wen for writes, 4'hF for reads)
- bus_addr  out  32  word-aligned address, cpu_addr with [1:0] forced to 0
- bus_wdata  out  32  write data
- bus_gnt  in  1  slave accepted the request this cycle
- bus_rvalid  in  1  response; for a read, bus_rdata is valid; a write gets a response too
- bus_rdata  in  32  read data
- bus_err  out  1  sticky timeout flag; cleared when the next access is accepted

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, cpu_rdata=0, bus_err=0, timeout counter=0. Reset mid-transaction drops bus_req immediately; late bus_gnt/bus_rvalid after release are ignored in IDLE.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE: when cpu_en=1, latch address/we/be/wdata into the bus registers, clear bus_err and the counter, then go to REQ. cpu_stall is combinational: high in this same cycle.
- REQ: bus_req=1 with the latched fields, held stable until bus_gnt. bus_gnt=1 -> RESP. bus_rvalid is ignored in REQ.
- RESP: bus_req=0. On bus_rvalid=1, capture cpu_rdata <= bus_rdata for reads (cpu_rdata unchanged for writes), then go to DONE.
- DONE: cpu_stall=0 for exactly one cycle so the core advances its memory stage at the end of it. Always go to IDLE next. cpu_en is ignored in DONE, so the same held request is never reissued.
- cpu_stall = (IDLE && cpu_en) || REQ || RESP.
- Minimum access: 4 cycles (IDLE, REQ with gnt, RESP with rvalid, DONE), i.e. stall high for 3 cycles. Each extra wait cycle on gnt or rvalid adds one stall cycle.
- Timeout counter:
  - Increments every cycle in REQ or RESP, saturating.
  - When it reaches TIMEOUT_CYCLES (nonzero): drop bus_req, set bus_err=1, cpu_rdata=ERR_RDATA for reads (writes leave it), go to DONE.
  - If bus_rvalid arrives in the same cycle as the timeout, the response wins and bus_err stays 0.
- Misaligned address bits are not checked here (the memory stage owns alignment); they are only masked off on bus_addr.
- cpu_rdata keeps its value through IDLE, so a stalled downstream stage sees stable data.

Test Plan:
- Zero-wait read: cpu_en=1, wen=0, addr=0x0000_1006; gnt in REQ, rvalid with rdata=0x1234_5678 on the next cycle -> bus_addr=0x0000_1004, bus_be=4'hF, stall high 3 cycles, cpu_rdata=0x1234_5678 in DONE, bus_req high exactly 1 cycle.
- Byte write with waits: wen=4'b0100, wdata=0x00AB_0000, gnt delayed 3 cycles, rvalid delayed 2 -> bus_we=1, bus_be=4'b0100, request fields stable during waits, stall high 8 cycles, cpu_rdata unchanged.
- Back-to-back: cpu_en held high across DONE with a new addr the cycle after DONE -> exactly one bus_req per access, no duplicate issue of the first.
- Timeout: TIMEOUT_CYCLES=8, bus_gnt never asserted -> after 8 REQ cycles bus_req=0, bus_err=1, cpu_rdata=0xDEAD_BEEF, DONE one cycle; the next access clears bus_err.
- Reset mid-RESP: assert rst low while waiting for rvalid -> bus_req=0 and all outputs at reset values immediately (no clock edge); rvalid pulse after release ignored, state IDLE.
- Timeout/response collision: rvalid arrives on the exact timeout cycle with rdata=0xCAFE_F00D -> cpu_rdata=0xCAFE_F00D, bus_err=0.
